// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Oversampling 8N1 UART receiver, LSB first, feeding the RX sync FIFO of
//   the AHB UART peripheral. The rx pin passes through a 2-flop synchroniser.
//   The start bit is confirmed at its mid-point. Each data bit and the stop
//   bit are then sampled one bit period apart. A good byte is pushed with a
//   one-cycle write strobe unless the FIFO is full. Framing errors and
//   overruns are reported as one-cycle pulses.
//
// Ports
//   clk          in   1  bus clock (hclk)
//   rst_n        in   1  synchronous active-low reset
//   rx           in   1  asynchronous serial input, idle high
//   full_i       in   1  RX FIFO full, looked at only on the stop-bit decision
//   data_o       out  8  last accepted byte, held until the next one
//   we_o         out  1  FIFO write strobe, one cycle per accepted byte
//   frame_err_o  out  1  one-cycle pulse, stop bit sampled low
//   overrun_o    out  1  one-cycle pulse, good byte dropped because FIFO full
//   busy_o       out  1  receiver is not idle
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       full_i,
  output logic [7:0] data_o,
  output logic       we_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic             rx_meta_q;
  logic             rx_s_q;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       sh_q;
  logic [7:0]       data_q;
  logic             we_q;
  logic             frame_err_q;
  logic             overrun_q;

  // Synchroniser flops reset to the idle (high) line level so that leaving
  // reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM. Status strobes default low every cycle so each one lasts
  // exactly one cycle and only one can be raised per frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      sh_q        <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      we_q        <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Start bit must still be low at its mid-point, otherwise it was a glitch.
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          // Counting starts at mid start bit, so every sample lands mid-bit.
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            sh_q  <= {rx_s_q, sh_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= IDLE;
              if (full_i) begin
                overrun_q <= 1'b1;
              end else begin
                data_q <= sh_q;
                we_q   <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          if (rx_s_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign we_o        = we_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser
//   Drives serial frames into uart_rx_deser and compares every strobe (kind,
//   data, cycle of arrival) against a frame-level reference model. The model
//   knows only the line timing: two synchroniser cycles, one cycle for the
//   idle detector, half a bit to the start mid-point and nine bit periods to
//   the stop decision.
module tb_uart_rx_deser;

  localparam int CPB      = 8;
  localparam int HALF     = CPB / 2;
  localparam int LATENCY  = 2 + 1 + HALF + 9 * CPB;
  localparam int KIND_WE  = 0;
  localparam int KIND_FE  = 1;
  localparam int KIND_OV  = 2;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       full_i;
  logic [7:0] data_o;
  logic       we_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checkCount;
  int errorCount;
  int cycleCount;
  int multiCount;

  int         evKind[$];
  int         evData[$];
  int         evCycle[$];
  int         expKind[$];
  int         expData[$];
  int         expCycle[$];
  logic [7:0] modelLast;

  uart_rx_deser #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .full_i      (full_i),
    .data_o      (data_o),
    .we_o        (we_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  // Free-running clock and an edge counter used as the time base.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Event monitor, sampled on the falling edge away from the active edge.
  initial multiCount = 0;
  always @(negedge clk) begin
    if ((int'(we_o) + int'(frame_err_o) + int'(overrun_o)) > 1) multiCount++;
    if (we_o) begin
      evKind.push_back(KIND_WE); evData.push_back(int'(data_o)); evCycle.push_back(cycleCount);
    end
    if (frame_err_o) begin
      evKind.push_back(KIND_FE); evData.push_back(int'(data_o)); evCycle.push_back(cycleCount);
    end
    if (overrun_o) begin
      evKind.push_back(KIND_OV); evData.push_back(int'(data_o)); evCycle.push_back(cycleCount);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cycleCount);
    end
  endtask

  // Sends one 8N1 frame starting at the current falling edge and records what
  // the receiver ought to report for it. Returns at the end of the stop bit.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit, input logic fullVal);
    int tDrive;
    tDrive = cycleCount;
    rx     = 1'b0;
    full_i = fullVal;
    if (!stopBit) begin
      expKind.push_back(KIND_FE); expData.push_back(int'(modelLast));
    end else if (fullVal) begin
      expKind.push_back(KIND_OV); expData.push_back(int'(modelLast));
    end else begin
      modelLast = value;
      expKind.push_back(KIND_WE); expData.push_back(int'(value));
    end
    expCycle.push_back(tDrive + LATENCY);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = value[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stopBit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idleLine(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkEvents(input string tag);
    checkOutput({tag, "/count"}, evKind.size(), expKind.size());
    for (int i = 0; i < expKind.size(); i++) begin
      if (i < evKind.size()) begin
        checkOutput({tag, "/kind"},  evKind[i],  expKind[i]);
        checkOutput({tag, "/data"},  evData[i],  expData[i]);
        checkOutput({tag, "/cycle"}, evCycle[i], expCycle[i]);
      end
    end
    evKind.delete(); evData.delete(); evCycle.delete();
    expKind.delete(); expData.delete(); expCycle.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "/data_o"},      int'(data_o),      0);
    checkOutput({tag, "/we_o"},        int'(we_o),        0);
    checkOutput({tag, "/frame_err_o"}, int'(frame_err_o), 0);
    checkOutput({tag, "/overrun_o"},   int'(overrun_o),   0);
    checkOutput({tag, "/busy_o"},      int'(busy_o),      0);
  endtask

  initial begin
    int         tDrive;
    int         gap;
    logic [7:0] partial;
    logic [7:0] value;
    logic       stopBit;
    logic       fullVal;

    checkCount = 0;
    errorCount = 0;
    modelLast  = 8'h00;
    rst_n      = 1'b0;
    rx         = 1'b1;
    full_i     = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain good frame.
    applyStimulus(8'hA5, 1'b1, 1'b0);
    idleLine(5);
    checkEvents("byteA5");
    checkOutput("byteA5/hold", int'(data_o), int'(modelLast));

    // Two-cycle low glitch must be rejected at the start-bit mid-point.
    tDrive = cycleCount;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("glitch/busyHigh", int'(busy_o), 1);
    repeat (4) @(negedge clk);
    checkOutput("glitch/busyLow", int'(busy_o), 0);
    idleLine(10);
    checkEvents("glitch");

    // Framing error followed by a break, then a good frame.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (32) @(negedge clk);
    checkOutput("break/busyHeld", int'(busy_o), 1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("break/busyLow", int'(busy_o), 0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    idleLine(5);
    checkEvents("break");
    checkOutput("break/hold", int'(data_o), int'(modelLast));

    // Overrun: data_o keeps the previous byte.
    applyStimulus(8'h5A, 1'b1, 1'b1);
    idleLine(5);
    full_i = 1'b0;
    checkEvents("overrun");
    checkOutput("overrun/hold", int'(data_o), 1);

    // Back-to-back frames with no idle gap.
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    idleLine(5);
    checkOutput("b2b/gap", (evCycle.size() >= 2) ? (evCycle[1] - evCycle[0]) : -1, CPB * 10);
    checkEvents("b2b");

    // Reset in the middle of data bit 3: the partial byte vanishes.
    partial = 8'h96;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (CPB) @(negedge clk);
    end
    rx = partial[3];
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midReset");
    rst_n = 1'b1;
    modelLast = 8'h00;
    idleLine(20);
    checkEvents("midReset");
    applyStimulus(8'h7E, 1'b1, 1'b0);
    idleLine(5);
    checkEvents("after7E");
    checkOutput("after7E/hold", int'(data_o), 8'h7E);

    // Randomised frames: random data, occasional bad stop or full FIFO,
    // random gaps including none, full_i wiggling between frames.
    for (int n = 0; n < 16; n++) begin
      value   = 8'($urandom);
      stopBit = ($urandom_range(0, 5) != 0);
      fullVal = ($urandom_range(0, 3) == 0);
      applyStimulus(value, stopBit, fullVal);
      if (!stopBit) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        idleLine(int'($urandom_range(2, 5)));
      end else begin
        gap = int'($urandom_range(0, 3));
        full_i = 1'($urandom);
        if (gap > 0) idleLine(gap);
      end
    end
    idleLine(10);
    checkEvents("random");
    checkOutput("random/hold", int'(data_o), int'(modelLast));

    checkOutput("exclusive", multiCount, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
